lstm_cell: RTL and testbench
============================

# lstm_cell

Single-timestep LSTM layer of NUM_LSTM units over a fixed-point input vector, with loadable weight/bias registers and recurrent cell/hidden state. Each enabled clock consumes one input frame, evaluates the four gates (candidate a, input i, forget f, output o), and updates the cell state c and hidden output h. It is the recurrent core of the training datapath: it exposes its weight registers (o_w_*, o_b_*) so a downstream backpropagation stage can read them.

## Interface
- Reset is asynchronous and active-low; `rst` and `clk` form the single clock/reset domain.
- WIDTH, 32, word width of every signed fixed-point value.
- FRAC, 24, fractional bits (Q(WIDTH-FRAC).FRAC); 1.0 = 0x01000000.
- NUM, 35, length of the concatenated gate input vector: NI = NUM-NUM_LSTM external inputs plus NUM_LSTM recurrent h values.
- NUM_LSTM, 1, number of LSTM units.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- sel  in  1  1 = load weights/biases and clear state; 0 = run one timestep per clock.
- i_x  in  NI*WIDTH  input frame; element k at [k*WIDTH +: WIDTH].
- i_w_a, i_w_i, i_w_f, i_w_o  in  NUM_LSTM*NUM*WIDTH  gate weights; unit u, element k at [(u*NUM+k)*WIDTH +: WIDTH].
- i_b_a, i_b_i, i_b_f, i_b_o  in  NUM_LSTM*WIDTH  gate biases per unit.
- o_w_a, o_w_i, o_w_f, o_w_o  out  NUM_LSTM*NUM*WIDTH  stored weight registers.
- o_b_a, o_b_i, o_b_f, o_b_o  out  NUM_LSTM*WIDTH  stored bias registers.
- o_a, o_i, o_f, o_o  out  NUM_LSTM*WIDTH  registered gate activations of the last step.
- o_c, o_h  out  NUM_LSTM*WIDTH  registered cell state and hidden output.

## Operation
- Concatenated vector v: v[k] = x[k] for k < NI; v[NI+u] = h_prev[u] (current o_h).
- Per unit u and gate g: z_g = b_g[u] + Σk w_g[u][k]·v[k].
  - Each product is the full 2*WIDTH-bit signed product, arithmetically shifted right by FRAC (floor).
  - Sum in a wide accumulator (≥ WIDTH+FRAC+clog2(NUM)+1 bits), then saturate to signed WIDTH.
- Activations (hard, deterministic):
  - tanh(z) = clamp(z, -1.0, +1.0).
  - sigmoid(z) = clamp(z/4 + 0.5, 0, 1.0); z/4 is an arithmetic shift by 2.
- Gate values: a = tanh(z_a); i, f, o = sigmoid(z_i, z_f, z_o).
- State update: c = sat(a·i + f·c_prev); h = o·tanh(c). Products use the same shift-by-FRAC rule; c saturates to signed WIDTH.
- sel=1:
  - Weight/bias registers ← i_w_*/i_b_*.
  - o_c, o_h, o_a, o_i, o_f, o_o ← 0.
  - No timestep is computed.
- sel=0:
  - Weights hold.
  - One timestep is computed using the stored weights and the current o_c/o_h; all gate and state registers update.

## Timing
- Reset (rst=0): every output, including weight/bias registers, goes to 0 immediately and asynchronously and is held while rst=0.
- Latency: one clock. Outputs after edge n reflect i_x sampled at edge n and state from edge n-1.
- Throughput: one timestep per clock; no handshake. i_x must be stable at each sel=0 edge.
- Reset asserted mid-sequence: all state and weights are lost; reload with sel=1 before resuming.
- sel=1 held for several cycles: weights reload each edge and state remains 0.

## Structure
- Shared package holds:
  - Fixed-point constants ONE = 1<<FRAC, HALF, NEG_ONE.
  - Saturate function and fixed-point multiply function (product >>> FRAC).
  - Hard sigmoid and hard tanh functions.
- Sub-module `lstm_gate`: one gate for one unit. It takes the v vector, a weight row and a bias, and produces the activated value through the MAC, saturate and activation stages, selected by a parameter (sigmoid or tanh).
- The top instantiates 4×NUM_LSTM gates and holds the c/h/weight registers.

## Test plan
- Reset: drive rst=0 asynchronously between clock edges -> all outputs 0 at once and remain 0 until rst is released.
- Zero weights/biases: sel=1 for 1 clk, then sel=0 for 1 clk -> o_a=0, o_i=o_f=o_o=0x00800000, o_c=0, o_h=0.
- Biases b_a=1.0, b_i=8.0, b_f=-8.0, b_o=8.0, all weights 0, one step -> i=1.0, f=0, o=1.0; o_c=0x01000000, o_h=0x01000000.
- Accumulate: b_a=0.5, b_i=b_f=b_o=8.0, three steps -> o_c = 0x00800000, 0x01000000, 0x01800000; o_h = 0x00800000, 0x01000000, 0x01000000.
- Weight path: x[0]=1.0, w_a[0][0]=0.25, b_i=b_o=8.0, b_f=-8.0 -> o_a=0x00400000, o_c=0x00400000, o_h=0x00400000.
- Recurrence and saturation:
  - w_a[0][NI]=1.0 with h_prev=1.0 -> a includes the recurrent term.
  - x and weights near 0x7FFFFFFF -> z saturates and a clamps to 1.0, with no wraparound.

Source files
------------

// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - fixed-point constants and arithmetic helpers for the LSTM cell
package lstm_pkg;

    localparam int WIDTH = 32;
    localparam int FRAC  = 24;
    localparam int ACC_W = 2 * WIDTH;

    localparam logic signed [WIDTH-1:0] ONE     = 32'sh0100_0000;
    localparam logic signed [WIDTH-1:0] HALF    = 32'sh0080_0000;
    localparam logic signed [WIDTH-1:0] NEG_ONE = 32'shFF00_0000;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > ACC_MAX)
            return ACC_MAX[WIDTH-1:0];
        else if (v < ACC_MIN)
            return ACC_MIN[WIDTH-1:0];
        else
            return v[WIDTH-1:0];
    endfunction

    // Full-width product, floor-shifted back to the Q8.24 scale.
    function automatic logic signed [ACC_W-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = a * b;
        return p >>> FRAC;
    endfunction

    function automatic logic signed [WIDTH-1:0] hard_tanh(input logic signed [WIDTH-1:0] z);
        if (z > ONE)
            return ONE;
        else if (z < NEG_ONE)
            return NEG_ONE;
        else
            return z;
    endfunction

    // z/4 + 0.5 cannot overflow WIDTH bits, so the clamp sees the true value.
    function automatic logic signed [WIDTH-1:0] hard_sigmoid(input logic signed [WIDTH-1:0] z);
        logic signed [WIDTH-1:0] s;
        s = (z >>> 2) + HALF;
        if (s > ONE)
            return ONE;
        else if (s < 0)
            return '0;
        else
            return s;
    endfunction

endpackage

// File: rtl/lstm_gate.sv
// rtl/lstm_gate.sv - one gate of one unit: dot product, bias, saturate, activation
module lstm_gate
    import lstm_pkg::*;
#(
    parameter int NUM     = 35,
    parameter bit IS_TANH = 1'b0
) (
    input  logic [NUM*WIDTH-1:0] v_i,
    input  logic [NUM*WIDTH-1:0] w_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [WIDTH-1:0]     act_o
);

    logic signed [ACC_W-1:0] acc;
    logic signed [WIDTH-1:0] z;

    always_comb begin
        acc = {{(ACC_W-WIDTH){b_i[WIDTH-1]}}, b_i};
        for (int k = 0; k < NUM; k++)
            acc = acc + fx_mul(v_i[k*WIDTH +: WIDTH], w_i[k*WIDTH +: WIDTH]);
    end

    assign z = sat(acc);

    generate
        if (IS_TANH) begin : g_tanh
            assign act_o = hard_tanh(z);
        end else begin : g_sigmoid
            assign act_o = hard_sigmoid(z);
        end
    endgenerate

endmodule

// File: rtl/lstm_cell.sv
// rtl/lstm_cell.sv - single-timestep LSTM layer with weight, cell and hidden state registers
module lstm_cell
    import lstm_pkg::*;
#(
    parameter int NUM      = 35,
    parameter int NUM_LSTM = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sel,
    input  logic [(NUM-NUM_LSTM)*WIDTH-1:0]   i_x,
    input  logic [NUM_LSTM*NUM*WIDTH-1:0]     i_w_a,
    input  logic [NUM_LSTM*NUM*WIDTH-1:0]     i_w_i,
    input  logic [NUM_LSTM*NUM*WIDTH-1:0]     i_w_f,
    input  logic [NUM_LSTM*NUM*WIDTH-1:0]     i_w_o,
    input  logic [NUM_LSTM*WIDTH-1:0]         i_b_a,
    input  logic [NUM_LSTM*WIDTH-1:0]         i_b_i,
    input  logic [NUM_LSTM*WIDTH-1:0]         i_b_f,
    input  logic [NUM_LSTM*WIDTH-1:0]         i_b_o,
    output logic [NUM_LSTM*NUM*WIDTH-1:0]     o_w_a,
    output logic [NUM_LSTM*NUM*WIDTH-1:0]     o_w_i,
    output logic [NUM_LSTM*NUM*WIDTH-1:0]     o_w_f,
    output logic [NUM_LSTM*NUM*WIDTH-1:0]     o_w_o,
    output logic [NUM_LSTM*WIDTH-1:0]         o_b_a,
    output logic [NUM_LSTM*WIDTH-1:0]         o_b_i,
    output logic [NUM_LSTM*WIDTH-1:0]         o_b_f,
    output logic [NUM_LSTM*WIDTH-1:0]         o_b_o,
    output logic [NUM_LSTM*WIDTH-1:0]         o_a,
    output logic [NUM_LSTM*WIDTH-1:0]         o_i,
    output logic [NUM_LSTM*WIDTH-1:0]         o_f,
    output logic [NUM_LSTM*WIDTH-1:0]         o_o,
    output logic [NUM_LSTM*WIDTH-1:0]         o_c,
    output logic [NUM_LSTM*WIDTH-1:0]         o_h
);

    localparam int WW = NUM_LSTM * NUM * WIDTH;
    localparam int BW = NUM_LSTM * WIDTH;
    localparam int RW = NUM * WIDTH;

    logic [WW-1:0] w_a_q, w_i_q, w_f_q, w_o_q;
    logic [BW-1:0] b_a_q, b_i_q, b_f_q, b_o_q;
    logic [BW-1:0] a_q, i_q, f_q, o_q, c_q, h_q;
    logic [BW-1:0] a_d, i_d, f_d, o_d, c_d, h_d;
    logic [RW-1:0] v;

    // Recurrent h values sit above the external inputs in the gate vector.
    assign v = {h_q, i_x};

    generate
        for (genvar u = 0; u < NUM_LSTM; u++) begin : g_unit
            lstm_gate #(.NUM(NUM), .IS_TANH(1'b1)) u_gate_a (
                .v_i(v), .w_i(w_a_q[u*RW +: RW]), .b_i(b_a_q[u*WIDTH +: WIDTH]),
                .act_o(a_d[u*WIDTH +: WIDTH]));
            lstm_gate #(.NUM(NUM), .IS_TANH(1'b0)) u_gate_i (
                .v_i(v), .w_i(w_i_q[u*RW +: RW]), .b_i(b_i_q[u*WIDTH +: WIDTH]),
                .act_o(i_d[u*WIDTH +: WIDTH]));
            lstm_gate #(.NUM(NUM), .IS_TANH(1'b0)) u_gate_f (
                .v_i(v), .w_i(w_f_q[u*RW +: RW]), .b_i(b_f_q[u*WIDTH +: WIDTH]),
                .act_o(f_d[u*WIDTH +: WIDTH]));
            lstm_gate #(.NUM(NUM), .IS_TANH(1'b0)) u_gate_o (
                .v_i(v), .w_i(w_o_q[u*RW +: RW]), .b_i(b_o_q[u*WIDTH +: WIDTH]),
                .act_o(o_d[u*WIDTH +: WIDTH]));
        end
    endgenerate

    always_comb begin
        c_d = '0;
        h_d = '0;
        for (int u = 0; u < NUM_LSTM; u++) begin
            c_d[u*WIDTH +: WIDTH] = sat(fx_mul(a_d[u*WIDTH +: WIDTH], i_d[u*WIDTH +: WIDTH])
                                      + fx_mul(f_d[u*WIDTH +: WIDTH], c_q[u*WIDTH +: WIDTH]));
            h_d[u*WIDTH +: WIDTH] = sat(fx_mul(o_d[u*WIDTH +: WIDTH],
                                               hard_tanh(c_d[u*WIDTH +: WIDTH])));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_a_q <= '0; w_i_q <= '0; w_f_q <= '0; w_o_q <= '0;
            b_a_q <= '0; b_i_q <= '0; b_f_q <= '0; b_o_q <= '0;
            a_q   <= '0; i_q   <= '0; f_q   <= '0; o_q   <= '0;
            c_q   <= '0; h_q   <= '0;
        end else if (sel) begin
            w_a_q <= i_w_a; w_i_q <= i_w_i; w_f_q <= i_w_f; w_o_q <= i_w_o;
            b_a_q <= i_b_a; b_i_q <= i_b_i; b_f_q <= i_b_f; b_o_q <= i_b_o;
            a_q   <= '0; i_q   <= '0; f_q   <= '0; o_q   <= '0;
            c_q   <= '0; h_q   <= '0;
        end else begin
            a_q <= a_d; i_q <= i_d; f_q <= f_d; o_q <= o_d;
            c_q <= c_d; h_q <= h_d;
        end
    end

    assign o_w_a = w_a_q;
    assign o_w_i = w_i_q;
    assign o_w_f = w_f_q;
    assign o_w_o = w_o_q;
    assign o_b_a = b_a_q;
    assign o_b_i = b_i_q;
    assign o_b_f = b_f_q;
    assign o_b_o = b_o_q;
    assign o_a   = a_q;
    assign o_i   = i_q;
    assign o_f   = f_q;
    assign o_o   = o_q;
    assign o_c   = c_q;
    assign o_h   = h_q;

endmodule

// File: tb/tb_lstm_cell.sv
// tb/tb_lstm_cell.sv - directed self-checking bench for lstm_cell
module tb_lstm_cell;
    import lstm_pkg::*;

    localparam int NUM = 35;
    localparam int NL  = 1;
    localparam int NI  = NUM - NL;

    localparam logic [31:0] P_ONE   = 32'h0100_0000;
    localparam logic [31:0] P_HALF  = 32'h0080_0000;
    localparam logic [31:0] P_QTR   = 32'h0040_0000;
    localparam logic [31:0] P_ONEH  = 32'h0180_0000;
    localparam logic [31:0] P_EIGHT = 32'h0800_0000;
    localparam logic [31:0] P_NEIGHT= 32'hF800_0000;
    localparam logic [31:0] P_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0] P_NMAX  = 32'h8000_0001;

    logic clk, rst, sel;
    logic [NI*WIDTH-1:0]     x;
    logic [NL*NUM*WIDTH-1:0] w_a, w_i, w_f, w_o;
    logic [NL*WIDTH-1:0]     b_a, b_i, b_f, b_o;
    logic [NL*NUM*WIDTH-1:0] ow_a, ow_i, ow_f, ow_o;
    logic [NL*WIDTH-1:0]     ob_a, ob_i, ob_f, ob_o;
    logic [NL*WIDTH-1:0]     oa, oi, of_, oo, oc, oh;

    int tests = 0;
    int fails = 0;

    lstm_cell #(.NUM(NUM), .NUM_LSTM(NL)) dut (
        .clk(clk), .rst(rst), .sel(sel), .i_x(x),
        .i_w_a(w_a), .i_w_i(w_i), .i_w_f(w_f), .i_w_o(w_o),
        .i_b_a(b_a), .i_b_i(b_i), .i_b_f(b_f), .i_b_o(b_o),
        .o_w_a(ow_a), .o_w_i(ow_i), .o_w_f(ow_f), .o_w_o(ow_o),
        .o_b_a(ob_a), .o_b_i(ob_i), .o_b_f(ob_f), .o_b_o(ob_o),
        .o_a(oa), .o_i(oi), .o_f(of_), .o_o(oo), .o_c(oc), .o_h(oh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cfg();
        x = '0;
        w_a = '0; w_i = '0; w_f = '0; w_o = '0;
        b_a = '0; b_i = '0; b_f = '0; b_o = '0;
    endtask

    task automatic load();
        sel = 1'b1;
        tick();
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        sel = 1'b0;
        clear_cfg();
        w_a = {(NUM){P_ONE}};
        b_i = P_EIGHT;
        #3;
        check("rst_c", oc, 32'h0);
        check("rst_h", oh, 32'h0);
        check("rst_bi", ob_i, 32'h0);
        tick();
        check("rst_hold_wa", ow_a[31:0], 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Zero weights and biases: sigmoids sit at one half.
        clear_cfg();
        load();
        tick();
        check("zero_a", oa, 32'h0);
        check("zero_i", oi, P_HALF);
        check("zero_f", of_, P_HALF);
        check("zero_o", oo, P_HALF);
        check("zero_c", oc, 32'h0);
        check("zero_h", oh, 32'h0);

        // Bias-only gates drive the sigmoids into their clamps.
        clear_cfg();
        b_a = P_ONE; b_i = P_EIGHT; b_f = P_NEIGHT; b_o = P_EIGHT;
        load();
        check("bias_rb_bf", ob_f, P_NEIGHT);
        tick();
        check("bias_i", oi, P_ONE);
        check("bias_f", of_, 32'h0);
        check("bias_o", oo, P_ONE);
        check("bias_c", oc, P_ONE);
        check("bias_h", oh, P_ONE);

        // Asynchronous reset between edges wipes state and weights.
        #3;
        rst = 1'b0;
        #1;
        check("arst_c", oc, 32'h0);
        check("arst_h", oh, 32'h0);
        check("arst_ba", ob_a, 32'h0);
        tick();
        check("arst_hold_bo", ob_o, 32'h0);
        check("arst_hold_i", oi, 32'h0);
        rst = 1'b1;

        // Accumulation with f = 1 over three steps.
        clear_cfg();
        b_a = P_HALF; b_i = P_EIGHT; b_f = P_EIGHT; b_o = P_EIGHT;
        load();
        tick();
        check("acc1_c", oc, P_HALF);
        check("acc1_h", oh, P_HALF);
        tick();
        check("acc2_c", oc, P_ONE);
        check("acc2_h", oh, P_ONE);
        tick();
        check("acc3_c", oc, P_ONEH);
        check("acc3_h", oh, P_ONE);

        // Holding sel high keeps reloading and keeps state at zero.
        sel = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            check($sformatf("selhold_c%0d", n), oc, 32'h0);
            check($sformatf("selhold_h%0d", n), oh, 32'h0);
        end
        sel = 1'b0;

        // Input weight path.
        clear_cfg();
        x[0 +: WIDTH]   = P_ONE;
        w_a[0 +: WIDTH] = P_QTR;
        b_i = P_EIGHT; b_f = P_NEIGHT; b_o = P_EIGHT;
        load();
        check("wp_rb_wa0", ow_a[31:0], P_QTR);
        tick();
        check("wp_a", oa, P_QTR);
        check("wp_c", oc, P_QTR);
        check("wp_h", oh, P_QTR);

        // Recurrent weight picks up the previous h.
        clear_cfg();
        w_a[NI*WIDTH +: WIDTH] = P_ONE;
        b_a = P_HALF; b_i = P_EIGHT; b_f = P_NEIGHT; b_o = P_EIGHT;
        load();
        tick();
        check("rec1_a", oa, P_HALF);
        check("rec1_h", oh, P_HALF);
        tick();
        check("rec2_a", oa, P_ONE);
        check("rec2_c", oc, P_ONE);

        // Huge positive and negative sums saturate rather than wrap.
        clear_cfg();
        x   = {(NI){P_MAX}};
        w_a = {(NUM){P_MAX}};
        w_i = {(NUM){P_MAX}};
        w_f = {(NUM){P_NMAX}};
        b_o = P_EIGHT;
        load();
        tick();
        check("sat_a", oa, P_ONE);
        check("sat_i", oi, P_ONE);
        check("sat_f", of_, 32'h0);
        check("sat_c", oc, P_ONE);
        check("sat_h", oh, P_ONE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
